alu_cmd_sequencer: RTL and testbench

- Initiator side of the ALU operand/opcode interface. Accepts tagged ALU commands over a valid/ready stream and buffers them in a small FIFO.
- Drives the combinational ALU's opcode, operand and shift inputs from registers, then captures result and flags one cycle later.
- Returns each outcome on a valid/ready response stream.
- Sits between a command source (test sequencer or micro-controller) and one generated ALU instance.

---
 rtl/alu_pkg.sv | 18 +
 rtl/sync_fifo.sv | 44 ++++
 rtl/alu_cmd_sequencer.sv | 143 ++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer: opcode map, legal-op count, FSM encoding.
package alu_pkg;
   localparam logic [3:0] OP_XOR   = 4'd0;
   localparam logic [3:0] OP_SRA   = 4'd1;
   localparam logic [3:0] OP_PASSB = 4'd2;
   localparam logic [3:0] OP_SLL   = 4'd3;
   localparam logic [3:0] OP_OR    = 4'd4;
   localparam logic [3:0] OP_SRL   = 4'd5;
   localparam logic [3:0] OP_SGE   = 4'd6;

   localparam int NUM_OPS = 7;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_RESP  = 2'd2
   } state_t;
endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; head entry is visible combinationally on o_rdata.
module sync_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_push,
   input  logic [W-1:0] i_wdata,
   input  logic         i_pop,
   output logic [W-1:0] o_rdata,
   output logic         o_full,
   output logic         o_empty
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] r_mem [DEPTH];
   logic [AW:0]  r_wr_ptr;
   logic [AW:0]  r_rd_ptr;
   logic         w_do_push;
   logic         w_do_pop;

   assign o_empty   = (r_wr_ptr == r_rd_ptr);
   assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_do_push = i_push && !o_full;
   assign w_do_pop  = i_pop && !o_empty;
   assign o_rdata   = r_mem[r_rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   // Storage is not reset; the pointers alone define what is valid.
   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
   end
endmodule

// File: rtl/alu_cmd_sequencer.sv
// Buffers tagged ALU commands, drives the ALU from registers and returns result/flags per command.
//
// state    | meaning
// ST_IDLE  | nothing in flight; pops the FIFO head as soon as one exists
// ST_ISSUE | alu_* drives settled this cycle; result/flags captured at its end
// ST_RESP  | response held on rsp_*; waits for rsp_ready
module alu_cmd_sequencer #(
   parameter int WIDTH     = 16,
   parameter int SHIFT_W   = 5,
   parameter int OPC_W     = 4,
   parameter int NUM_OPS   = alu_pkg::NUM_OPS,
   parameter int CMD_DEPTH = 4,
   parameter int TAG_W     = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [OPC_W-1:0]   cmd_opcode,
   input  logic [WIDTH-1:0]   cmd_a,
   input  logic [WIDTH-1:0]   cmd_b,
   input  logic [SHIFT_W-1:0] cmd_shift,
   input  logic [TAG_W-1:0]   cmd_tag,
   output logic [OPC_W-1:0]   alu_opcode,
   output logic [WIDTH-1:0]   alu_input1,
   output logic [WIDTH-1:0]   alu_input2,
   output logic [SHIFT_W-1:0] alu_shift,
   input  logic [WIDTH-1:0]   alu_result,
   input  logic               alu_carry,
   input  logic               alu_zero,
   input  logic               alu_sign,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [WIDTH-1:0]   rsp_result,
   output logic               rsp_carry,
   output logic               rsp_zero,
   output logic               rsp_sign,
   output logic [TAG_W-1:0]   rsp_tag,
   output logic               rsp_err,
   output logic               busy,
   output logic [15:0]        issue_count
);
   import alu_pkg::*;

   localparam int EW = OPC_W + 2*WIDTH + SHIFT_W + TAG_W;

   state_t             r_state;
   logic [TAG_W-1:0]   r_cur_tag;
   logic [EW-1:0]      w_head;
   logic               w_full;
   logic               w_empty;
   logic               w_pop;
   logic               w_head_legal;
   logic [OPC_W-1:0]   w_head_opc;
   logic [WIDTH-1:0]   w_head_a;
   logic [WIDTH-1:0]   w_head_b;
   logic [SHIFT_W-1:0] w_head_shift;
   logic [TAG_W-1:0]   w_head_tag;

   assign cmd_ready = !w_full;
   assign busy      = !w_empty || (r_state != ST_IDLE);

   sync_fifo #(.W(EW), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (cmd_valid && cmd_ready),
      .i_wdata ({cmd_opcode, cmd_a, cmd_b, cmd_shift, cmd_tag}),
      .i_pop   (w_pop),
      .o_rdata (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   assign w_head_opc   = w_head[EW-1 -: OPC_W];
   assign w_head_a     = w_head[TAG_W+SHIFT_W+WIDTH +: WIDTH];
   assign w_head_b     = w_head[TAG_W+SHIFT_W +: WIDTH];
   assign w_head_shift = w_head[TAG_W +: SHIFT_W];
   assign w_head_tag   = w_head[TAG_W-1:0];
   assign w_head_legal = (32'(w_head_opc) < 32'(NUM_OPS));

   // A new command is taken either from IDLE or in the same edge a response is consumed.
   assign w_pop = !w_empty &&
                  ((r_state == ST_IDLE) || (r_state == ST_RESP && rsp_ready));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_cur_tag   <= '0;
         alu_opcode  <= '0;
         alu_input1  <= '0;
         alu_input2  <= '0;
         alu_shift   <= '0;
         rsp_valid   <= 1'b0;
         rsp_result  <= '0;
         rsp_carry   <= 1'b0;
         rsp_zero    <= 1'b0;
         rsp_sign    <= 1'b0;
         rsp_tag     <= '0;
         rsp_err     <= 1'b0;
         issue_count <= '0;
      end else if (w_pop) begin
         if (w_head_legal) begin
            alu_opcode <= w_head_opc;
            alu_input1 <= w_head_a;
            alu_input2 <= w_head_b;
            alu_shift  <= w_head_shift;
            r_cur_tag  <= w_head_tag;
            rsp_valid  <= 1'b0;
            r_state    <= ST_ISSUE;
         end else begin
            rsp_result <= '0;
            rsp_carry  <= 1'b0;
            rsp_zero   <= 1'b0;
            rsp_sign   <= 1'b0;
            rsp_tag    <= w_head_tag;
            rsp_err    <= 1'b1;
            rsp_valid  <= 1'b1;
            r_state    <= ST_RESP;
         end
      end else begin
         case (r_state)
            ST_ISSUE: begin
               rsp_result  <= alu_result;
               rsp_carry   <= alu_carry;
               rsp_zero    <= alu_zero;
               rsp_sign    <= alu_sign;
               rsp_tag     <= r_cur_tag;
               rsp_err     <= 1'b0;
               rsp_valid   <= 1'b1;
               issue_count <= issue_count + 16'd1;
               r_state     <= ST_RESP;
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  r_state   <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer driving a behavioural 16-bit ALU.
module tb_alu_cmd_sequencer;
   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [3:0]  cmd_opcode;
   logic [15:0] cmd_a;
   logic [15:0] cmd_b;
   logic [4:0]  cmd_shift;
   logic [3:0]  cmd_tag;
   logic [3:0]  alu_opcode;
   logic [15:0] alu_input1;
   logic [15:0] alu_input2;
   logic [4:0]  alu_shift;
   logic [15:0] alu_result;
   logic        alu_carry;
   logic        alu_zero;
   logic        alu_sign;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [15:0] rsp_result;
   logic        rsp_carry;
   logic        rsp_zero;
   logic        rsp_sign;
   logic [3:0]  rsp_tag;
   logic        rsp_err;
   logic        busy;
   logic [15:0] issue_count;
   logic [16:0] w_sll;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   alu_cmd_sequencer dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_shift(cmd_shift), .cmd_tag(cmd_tag),
      .alu_opcode(alu_opcode), .alu_input1(alu_input1), .alu_input2(alu_input2),
      .alu_shift(alu_shift), .alu_result(alu_result), .alu_carry(alu_carry),
      .alu_zero(alu_zero), .alu_sign(alu_sign),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
      .rsp_carry(rsp_carry), .rsp_zero(rsp_zero), .rsp_sign(rsp_sign),
      .rsp_tag(rsp_tag), .rsp_err(rsp_err), .busy(busy), .issue_count(issue_count)
   );

   assign w_sll = {1'b0, alu_input1} << alu_shift;

   always_comb begin
      alu_result = 16'h0000;
      alu_carry  = 1'b0;
      case (alu_opcode)
         4'd0: alu_result = alu_input1 ^ alu_input2;
         4'd1: alu_result = $signed(alu_input1) >>> alu_shift;
         4'd2: alu_result = alu_input2;
         4'd3: begin alu_result = w_sll[15:0]; alu_carry = w_sll[16]; end
         4'd4: alu_result = alu_input1 | alu_input2;
         4'd5: alu_result = alu_input1 >> alu_shift;
         4'd6: alu_result = ($signed(alu_input1) >= $signed(alu_input2)) ? 16'd1 : 16'd0;
         default: alu_result = 16'h0000;
      endcase
      alu_zero = (alu_result == 16'h0000);
      alu_sign = alu_result[15];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [4:0] sh, input logic [3:0] tg);
      cmd_valid  = 1'b1;
      cmd_opcode = op;
      cmd_a      = a;
      cmd_b      = b;
      cmd_shift  = sh;
      cmd_tag    = tg;
   endtask

   initial begin
      int accepted;
      int got;
      logic take;

      rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
      cmd_opcode = '0; cmd_a = '0; cmd_b = '0; cmd_shift = '0; cmd_tag = '0;
      step(); step();
      rst = 1'b0;
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_cmd_ready", 32'(cmd_ready), 1);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_issue_count", 32'(issue_count), 0);
      chk("rst_alu_opcode", 32'(alu_opcode), 0);
      chk("rst_alu_input1", 32'(alu_input1), 0);
      chk("rst_rsp_result", 32'(rsp_result), 0);

      // XOR single command, latency two edges after accept
      drive(4'd0, 16'h00FF, 16'h0F0F, 5'd0, 4'd3);
      step(); cmd_valid = 1'b0;
      chk("xor_valid_n", 32'(rsp_valid), 0);
      step();
      chk("xor_valid_n1", 32'(rsp_valid), 0);
      chk("xor_alu_opcode", 32'(alu_opcode), 0);
      chk("xor_alu_input1", 32'(alu_input1), 32'h00FF);
      step();
      chk("xor_valid_n2", 32'(rsp_valid), 1);
      chk("xor_result", 32'(rsp_result), 32'h0FF0);
      chk("xor_zero", 32'(rsp_zero), 0);
      chk("xor_sign", 32'(rsp_sign), 0);
      chk("xor_tag", 32'(rsp_tag), 3);
      chk("xor_err", 32'(rsp_err), 0);
      chk("xor_issue_count", 32'(issue_count), 1);
      rsp_ready = 1'b1;
      step();
      chk("xor_done_valid", 32'(rsp_valid), 0);
      chk("xor_done_busy", 32'(busy), 0);

      // SRA then SLL back-to-back, rsp_ready high
      drive(4'd1, 16'h8000, 16'h0000, 5'd4, 4'd1);
      step();
      drive(4'd3, 16'h0001, 16'h0000, 5'd15, 4'd2);
      step(); cmd_valid = 1'b0;
      step();
      chk("sra_valid", 32'(rsp_valid), 1);
      chk("sra_result", 32'(rsp_result), 32'hF800);
      chk("sra_sign", 32'(rsp_sign), 1);
      chk("sra_tag", 32'(rsp_tag), 1);
      step();
      chk("sll_gap_valid", 32'(rsp_valid), 0);
      step();
      chk("sll_valid", 32'(rsp_valid), 1);
      chk("sll_result", 32'(rsp_result), 32'h8000);
      chk("sll_sign", 32'(rsp_sign), 1);
      chk("sll_carry", 32'(rsp_carry), 0);
      chk("sll_tag", 32'(rsp_tag), 2);
      chk("sll_issue_count", 32'(issue_count), 3);
      step();
      chk("sll_done_valid", 32'(rsp_valid), 0);

      // Illegal opcode: error response, no issue, ALU drives untouched
      rsp_ready = 1'b0;
      drive(4'd9, 16'h1234, 16'h5678, 5'd2, 4'd7);
      step(); cmd_valid = 1'b0;
      step(); step();
      chk("ill_valid", 32'(rsp_valid), 1);
      chk("ill_err", 32'(rsp_err), 1);
      chk("ill_result", 32'(rsp_result), 0);
      chk("ill_flags", 32'({rsp_carry, rsp_zero, rsp_sign}), 0);
      chk("ill_tag", 32'(rsp_tag), 7);
      chk("ill_issue_count", 32'(issue_count), 3);
      chk("ill_alu_opcode", 32'(alu_opcode), 3);
      chk("ill_alu_input1", 32'(alu_input1), 32'h0001);
      chk("ill_alu_shift", 32'(alu_shift), 15);
      rsp_ready = 1'b1;
      step();
      chk("ill_done_valid", 32'(rsp_valid), 0);

      // Capacity: rsp_ready low, six OR commands offered, five absorbed
      rsp_ready = 1'b0;
      accepted = 0;
      for (int c = 0; c < 10; c++) begin
         drive(4'd4, 16'(accepted), 16'h0100, 5'd0, 4'(accepted));
         take = cmd_ready;
         step();
         if (take) accepted++;
      end
      chk("cap_accepted", 32'(accepted), 5);
      chk("cap_cmd_ready", 32'(cmd_ready), 0);
      rsp_ready = 1'b1;
      got = 0;
      for (int c = 0; c < 40 && got < 6; c++) begin
         if (rsp_valid) begin
            chk("cap_result", 32'(rsp_result), 32'h0100 | 32'(got));
            chk("cap_tag", 32'(rsp_tag), 32'(got));
            got++;
         end
         take = cmd_valid && cmd_ready;
         step();
         if (take) cmd_valid = 1'b0;
      end
      chk("cap_responses", 32'(got), 6);
      chk("cap_issue_count", 32'(issue_count), 9);

      // PASSB of zero sets the zero flag
      step();
      rsp_ready = 1'b0;
      drive(4'd2, 16'hABCD, 16'h0000, 5'd0, 4'd5);
      step(); cmd_valid = 1'b0;
      step(); step();
      chk("passb_valid", 32'(rsp_valid), 1);
      chk("passb_result", 32'(rsp_result), 0);
      chk("passb_zero", 32'(rsp_zero), 1);
      chk("passb_tag", 32'(rsp_tag), 5);
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;

      // Reset while in ISSUE with three queued
      accepted = 0;
      for (int c = 0; c < 5; c++) begin
         drive(4'd0, 16'(c), 16'h0001, 5'd0, 4'(c));
         take = cmd_ready;
         step();
         if (take) accepted++;
      end
      cmd_valid = 1'b0;
      chk("rstmid_accepted", 32'(accepted), 5);
      chk("rstmid_resp_held", 32'(rsp_valid), 1);
      rsp_ready = 1'b1;
      step();
      chk("rstmid_in_issue_valid", 32'(rsp_valid), 0);
      chk("rstmid_in_issue_busy", 32'(busy), 1);
      rst = 1'b1; rsp_ready = 1'b0;
      step();
      rst = 1'b0;
      chk("rstmid_valid", 32'(rsp_valid), 0);
      chk("rstmid_busy", 32'(busy), 0);
      chk("rstmid_issue_count", 32'(issue_count), 0);
      chk("rstmid_cmd_ready", 32'(cmd_ready), 1);
      chk("rstmid_alu_opcode", 32'(alu_opcode), 0);
      rsp_ready = 1'b1;
      for (int c = 0; c < 5; c++) step();
      chk("rstmid_no_stale_valid", 32'(rsp_valid), 0);
      chk("rstmid_no_stale_busy", 32'(busy), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
